freq_div_prog: RTL and testbench
================================

# freq_div_prog

Programmable, fully synchronous frequency divider. It is the successor to the fixed 2^21 ripple divider chain. All state runs on the single system clock, and it produces a divided square wave plus a one-cycle tick strobe. The tick is intended as a clock enable for downstream logic such as display multiplexing, debounce and slow counters. The divisor can be changed at run time without glitches, and the output phase can be re-aligned on demand.

## Interface
- WIDTH, 22: counter and divisor width in bits; legal divisors are 1..2^WIDTH-1.
- DEFAULT_DIV, 2097152: divisor loaded at reset (2^21, matching the legacy divide ratio); must be nonzero and fit in WIDTH bits.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  count enable; when low, the counter, clk_out, div_cur and pending state hold.
- resync  in  1  one-cycle request to restart the period immediately.
- div_load  in  1  one-cycle strobe that captures div_in as a new divisor.
- div_in  in  WIDTH  requested divisor; sampled only when div_load=1.
- clk_out  out  1  divided square wave (registered).
- tick  out  1  one-cycle pulse at the start of each period (registered).
- div_cur  out  WIDTH  divisor currently in effect.
- pend  out  1  a loaded divisor is waiting for the next period boundary.
- load_err  out  1  one-cycle pulse: div_load was given div_in=0 and was rejected.

## Operation
- Internal state:
  - cnt[WIDTH]: counter.
  - div[WIDTH]: active divisor (drives div_cur).
  - pdiv[WIDTH] with flag pend: pending divisor.
  - H = div - (div>>1): high-phase length, equal to ceil(div/2).
- Reset (rst_n=0 at an edge) sets:
  - cnt=0, div=DEFAULT_DIV, pdiv=0, pend=0;
  - clk_out=0, tick=0, load_err=0.
- Priority per edge: rst_n, then resync, then en.
- Wrap event, on an enabled edge with cnt==div-1:
  - cnt<=0, clk_out<=1, tick<=1;
  - if pend=1, then div<=pdiv and pend<=0.
- Non-wrap event, on an enabled edge:
  - cnt<=cnt+1 and tick<=0;
  - if cnt+1==H, clk_out<=0.
- en=0 with no resync:
  - tick<=0;
  - cnt, clk_out, div and pend hold.
- Resync: behaves as a forced wrap (cnt<=0, clk_out<=1, tick<=1, pending divisor applied) and acts regardless of en.
- Divisor loading:
  - div_load=1 with div_in!=0: pdiv<=div_in, pend<=1. A second load before the boundary overwrites pdiv (last write wins).
  - div_load=1 with div_in==0: pdiv and pend are unchanged, load_err<=1 for one cycle. load_err is otherwise 0.
  - div_load on the same edge as a natural wrap: the new value goes to pending and takes effect at the following wrap. Any older pending value is discarded, not applied.
  - div_load (valid) on the same edge as resync: div<=div_in directly, pend<=0.
- Resulting waveform: period = div enabled cycles; clk_out is high for H cycles and low for div-H cycles.
  - div=1: clk_out stays 1 and tick is high every enabled cycle.
  - Odd div: the high phase is one cycle longer than the low phase.
- Arithmetic: all compares are WIDTH-bit unsigned; cnt never exceeds div-1. div is always nonzero, so div-1 does not underflow.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- After reset release with en=1:
  - the first wrap occurs on the div-th enabled edge;
  - clk_out and tick rise together on that edge.
- tick is high for exactly one cycle per period, aligned with the cycle in which clk_out goes high.
- div_cur changes only on a wrap or resync edge, in the same cycle that tick rises.
- pend rises the cycle after a valid div_load and falls on the edge that applies the value.
- resync: tick=1 and clk_out=1 in the cycle after the request; the next tick follows exactly div_cur enabled cycles later.
- Deasserting en mid-period stretches the period by the number of disabled cycles and produces no glitch on clk_out.

## Test plan
- Reset, then en=1 with DEFAULT_DIV overridden to 4 → clk_out reads 0,0,0,0 then repeats 1,1,0,0; tick is high in each cycle where clk_out rises; div_cur=4.
- div=5, then div_load div_in=3 mid-period → pend=1 until the next wrap; that period stays at 5 cycles (high 3, low 2); subsequent periods are 3 cycles (high 2, low 1); pend returns to 0.
- div_load with div_in=0 → load_err pulses once; pend, div_cur and the waveform are unchanged; a later valid load still works.
- div=6, resync asserted at cnt=2 → tick and clk_out are 1 on the next cycle; the following tick comes exactly 6 cycles later; resync together with div_load=2 → div_cur=2 immediately.
- en toggled low for 3 cycles at cnt=1 with div=4 → the period measures 7 clock cycles, tick stays 0 while disabled, clk_out holds its level.
- rst_n pulled low mid-period with pend=1 → the next cycle shows clk_out=0, tick=0, pend=0 and div_cur=DEFAULT_DIV.

Source files
------------

// File: rtl/freq_div_prog.sv
// ============================================================================
// Module   : freq_div_prog
// Purpose  : Programmable synchronous frequency divider producing a divided
//            square wave and a one-cycle tick strobe, with glitch-free run-time
//            divisor changes and on-demand phase resync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_div_prog #(
    parameter int          WIDTH       = 22,
    parameter int unsigned DEFAULT_DIV = 2097152
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             resync,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_cur,
    output logic             pend,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] c_ZERO        = '0;
    localparam logic [WIDTH-1:0] c_ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pdiv;
    logic             r_pend;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_load_err;

    logic [WIDTH-1:0] w_div_m1;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_half;
    logic             w_wrap;
    logic             w_boundary;
    logic             w_load_ok;
    logic             w_load_bad;

    // High phase is ceil(div/2) so odd divisors spend the extra cycle high.
    assign w_div_m1   = r_div - c_ONE;
    assign w_cnt_inc  = r_cnt + c_ONE;
    assign w_half     = r_div - (r_div >> 1);
    assign w_wrap     = (r_cnt == w_div_m1);
    assign w_boundary = resync | (en & w_wrap);
    assign w_load_ok  = div_load & (div_in != c_ZERO);
    assign w_load_bad = div_load & (div_in == c_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= c_ZERO;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_boundary) begin
            r_cnt     <= c_ZERO;
            r_clk_out <= 1'b1;
            r_tick    <= 1'b1;
        end else if (en) begin
            r_cnt  <= w_cnt_inc;
            r_tick <= 1'b0;
            if (w_cnt_inc == w_half) begin
                r_clk_out <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // A valid load alongside resync bypasses the pending slot entirely; a load
    // on a natural wrap replaces (and thereby discards) any older pending value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div      <= c_DEFAULT_DIV;
            r_pdiv     <= c_ZERO;
            r_pend     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= w_load_bad;
            if (resync && w_load_ok) begin
                r_div  <= div_in;
                r_pend <= 1'b0;
            end else if (w_load_ok) begin
                r_pdiv <= div_in;
                r_pend <= 1'b1;
            end else if (w_boundary && r_pend) begin
                r_div  <= r_pdiv;
                r_pend <= 1'b0;
            end
        end
    end

    assign clk_out  = r_clk_out;
    assign tick     = r_tick;
    assign div_cur  = r_div;
    assign pend     = r_pend;
    assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_freq_div_prog.sv
// ============================================================================
// Module   : tb_freq_div_prog
// Purpose  : Scoreboard bench for freq_div_prog with hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_div_prog;

    localparam int W = 22;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         resync = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] div_cur;
    logic         pend;
    logic         load_err;

    freq_div_prog #(
        .WIDTH       (W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .resync   (resync),
        .div_load (div_load),
        .div_in   (div_in),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_cur  (div_cur),
        .pend     (pend),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {clk_out, tick, div_cur, pend, load_err} per cycle.
    int               q_cyc[$];
    logic [W+3:0]     q_val[$];
    string            q_name[$];

    task automatic v(input int rn, input int e, input int rs, input int ld, input int din,
                     input int eclk, input int etk, input int ediv, input int epd, input int eer,
                     input string nm);
        @(negedge clk);
        rst_n    = 1'(rn);
        en       = 1'(e);
        resync   = 1'(rs);
        div_load = 1'(ld);
        div_in   = W'(din);
        q_cyc.push_back(cyc + 1);
        q_val.push_back({1'(eclk), 1'(etk), W'(ediv), 1'(epd), 1'(eer)});
        q_name.push_back(nm);
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output word.
    initial begin
        logic [W+3:0] got;
        logic [W+3:0] exp;
        int           ec;
        string        nm;
        forever begin
            @(posedge clk);
            #2;
            while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                ec  = q_cyc.pop_front();
                exp = q_val.pop_front();
                nm  = q_name.pop_front();
                got = {clk_out, tick, div_cur, pend, load_err};
                checks++;
                if (ec != cyc) begin
                    errors++;
                    $display("FAIL %s missed sample cyc=%0d now=%0d", nm, ec, cyc);
                end else if (got !== exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got clk_out=%b tick=%b div_cur=%0d pend=%b load_err=%b exp clk_out=%b tick=%b div_cur=%0d pend=%b load_err=%b",
                             nm, cyc, got[W+3], got[W+2], got[W+1:2], got[1], got[0],
                             exp[W+3], exp[W+2], exp[W+1:2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and default divide-by-4 waveform
        v(0,0,0,0,0, 0,0,4,0,0, "reset");
        v(0,1,1,1,9, 0,0,4,0,0, "reset_priority");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_e1");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_e2");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_e3");
        v(1,1,0,0,0, 1,1,4,0,0, "d4_first_wrap");
        v(1,1,0,0,0, 1,0,4,0,0, "d4_hi");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_lo");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_lo");
        v(1,1,0,0,0, 1,1,4,0,0, "d4_wrap2");
        v(1,1,0,0,0, 1,0,4,0,0, "d4_hi");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_lo");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_lo");
        v(1,1,0,0,0, 1,1,4,0,0, "d4_wrap3");

        // div 5 with a pending load of 3 mid-period, then zero-load rejection
        v(0,0,0,0,0, 0,0,4,0,0, "reset2");
        v(1,1,1,1,5, 1,1,5,0,0, "resync_load5");
        v(1,1,0,0,0, 1,0,5,0,0, "d5_hi");
        v(1,1,0,1,3, 1,0,5,1,0, "load3_pending");
        v(1,1,0,0,0, 0,0,5,1,0, "d5_lo");
        v(1,1,0,0,0, 0,0,5,1,0, "d5_lo");
        v(1,1,0,0,0, 1,1,3,0,0, "apply3");
        v(1,1,0,0,0, 1,0,3,0,0, "d3_hi");
        v(1,1,0,0,0, 0,0,3,0,0, "d3_lo");
        v(1,1,0,0,0, 1,1,3,0,0, "d3_wrap");
        v(1,1,0,0,0, 1,0,3,0,0, "d3_hi");
        v(1,1,0,0,0, 0,0,3,0,0, "d3_lo");
        v(1,1,0,0,0, 1,1,3,0,0, "d3_wrap");
        v(1,1,0,1,0, 1,0,3,0,1, "zero_load_err");
        v(1,1,0,0,0, 0,0,3,0,0, "err_clears");
        v(1,1,0,0,0, 1,1,3,0,0, "d3_wrap");
        v(1,1,0,1,4, 1,0,3,1,0, "load4_pending");
        v(1,1,0,1,0, 0,0,3,1,1, "zero_while_pend");
        v(1,1,0,0,0, 1,1,4,0,0, "apply4");
        v(1,1,0,0,0, 1,0,4,0,0, "d4_hi");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_lo");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_lo");
        v(1,1,0,0,0, 1,1,4,0,0, "d4_wrap");

        // load coinciding with a natural wrap discards the older pending value
        v(0,0,0,0,0, 0,0,4,0,0, "reset3");
        v(1,1,0,1,5, 0,0,4,1,0, "load5_pending");
        v(1,1,0,0,0, 0,0,4,1,0, "d4_e2");
        v(1,1,0,0,0, 0,0,4,1,0, "d4_e3");
        v(1,1,0,1,3, 1,1,4,1,0, "wrap_load3");
        v(1,1,0,0,0, 1,0,4,1,0, "d4_hi");
        v(1,1,0,0,0, 0,0,4,1,0, "d4_lo");
        v(1,1,0,0,0, 0,0,4,1,0, "d4_lo");
        v(1,1,0,0,0, 1,1,3,0,0, "apply3_not5");
        v(1,1,0,0,0, 1,0,3,0,0, "d3_hi");
        v(1,1,0,0,0, 0,0,3,0,0, "d3_lo");
        v(1,1,0,0,0, 1,1,3,0,0, "d3_wrap");

        // resync behaviour, div 2, div 1 and maximum divisor
        v(0,0,0,0,0, 0,0,4,0,0, "reset4");
        v(1,1,1,1,6, 1,1,6,0,0, "resync_load6");
        v(1,1,0,0,0, 1,0,6,0,0, "d6_c1");
        v(1,1,0,0,0, 1,0,6,0,0, "d6_c2");
        v(1,1,1,0,0, 1,1,6,0,0, "resync_at_cnt2");
        v(1,1,0,0,0, 1,0,6,0,0, "d6_hi");
        v(1,1,0,0,0, 1,0,6,0,0, "d6_hi");
        v(1,1,0,0,0, 0,0,6,0,0, "d6_lo");
        v(1,1,0,0,0, 0,0,6,0,0, "d6_lo");
        v(1,1,0,0,0, 0,0,6,0,0, "d6_lo");
        v(1,1,0,0,0, 1,1,6,0,0, "d6_tick_after6");
        v(1,1,0,0,0, 1,0,6,0,0, "d6_hi");
        v(1,1,1,1,2, 1,1,2,0,0, "resync_load2");
        v(1,1,0,0,0, 0,0,2,0,0, "d2_lo");
        v(1,1,0,0,0, 1,1,2,0,0, "d2_wrap");
        v(1,1,0,0,0, 0,0,2,0,0, "d2_lo");
        v(1,1,0,0,0, 1,1,2,0,0, "d2_wrap");
        v(1,1,0,1,3, 0,0,2,1,0, "load3_pending");
        v(1,1,1,0,0, 1,1,3,0,0, "resync_applies_pend");
        v(1,1,0,0,0, 1,0,3,0,0, "d3_hi");
        v(1,1,0,0,0, 0,0,3,0,0, "d3_lo");
        v(1,1,0,0,0, 1,1,3,0,0, "d3_wrap");
        v(1,1,1,1,1, 1,1,1,0,0, "resync_load1");
        v(1,1,0,0,0, 1,1,1,0,0, "d1_tick");
        v(1,1,0,0,0, 1,1,1,0,0, "d1_tick");
        v(1,0,0,0,0, 1,0,1,0,0, "d1_disabled");
        v(1,1,0,0,0, 1,1,1,0,0, "d1_tick");
        v(1,1,1,1,32'h3FFFFF, 1,1,32'h3FFFFF,0,0, "resync_load_max");
        v(1,1,0,0,0, 1,0,32'h3FFFFF,0,0, "dmax_hi");
        v(1,1,0,0,0, 1,0,32'h3FFFFF,0,0, "dmax_hi");

        // enable gaps stretch the period; resync works while disabled
        v(0,0,0,0,0, 0,0,4,0,0, "reset5");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_e1");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_e2");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_e3");
        v(1,1,0,0,0, 1,1,4,0,0, "d4_wrap");
        v(1,1,0,0,0, 1,0,4,0,0, "d4_cnt1");
        v(1,0,0,0,0, 1,0,4,0,0, "en_off1");
        v(1,0,0,0,0, 1,0,4,0,0, "en_off2");
        v(1,0,0,0,0, 1,0,4,0,0, "en_off3");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_cnt2");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_cnt3");
        v(1,1,0,0,0, 1,1,4,0,0, "period7_wrap");
        v(1,0,1,0,0, 1,1,4,0,0, "resync_while_off");
        v(1,0,0,0,0, 1,0,4,0,0, "off_hold");
        v(1,1,0,0,0, 1,0,4,0,0, "d4_hi");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_lo");
        v(1,1,0,0,0, 0,0,4,0,0, "d4_lo");
        v(1,1,0,0,0, 1,1,4,0,0, "d4_wrap");

        // reset mid-period with a pending divisor
        v(1,1,0,1,7, 1,0,4,1,0, "load7_pending");
        v(0,1,0,1,0, 0,0,4,0,0, "reset_mid");
        v(1,1,0,0,0, 0,0,4,0,0, "post_rst_e1");
        v(1,1,0,0,0, 0,0,4,0,0, "post_rst_e2");
        v(1,1,0,0,0, 0,0,4,0,0, "post_rst_e3");
        v(1,1,0,0,0, 1,1,4,0,0, "post_rst_wrap");

        repeat (3) @(negedge clk);
        checks++;
        if (q_cyc.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", q_cyc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
